// File: rtl/rc_clkgen_multi_if.sv
// Bundle of per-channel enable/divider inputs and clock/status outputs.
interface rc_clkgen_multi_if #(
  parameter int unsigned NCH  = 2,
  parameter int unsigned DIVW = 16
);
  logic [NCH-1:0]      en;
  logic [NCH*DIVW-1:0] div;
  logic [NCH-1:0]      clk_out;
  logic [NCH-1:0]      ready;
  logic [NCH-1:0]      tick;

  modport master (output en, output div, input clk_out, input ready, input tick);
  modport slave  (input en, input div, output clk_out, output ready, output tick);
endinterface

// File: rtl/rc_clkgen_multi.sv
// Multi-channel, enable-gated, programmable-frequency clock generator.
// Each channel warms up, runs at a period of 2*hp system cycles, and stops only after
// finishing a high phase, so no runt pulses appear on clk_out.
module rc_clkgen_multi #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned DIVW    = 16,
  parameter int unsigned STARTUP = 4
) (
  input logic          clk,
  input logic          reset,
  rc_clkgen_multi_if.slave bus
);

  typedef enum logic [1:0] {StOff, StWarm, StRun, StStop} state_e;

  localparam int unsigned WarmW = (STARTUP > 2) ? $clog2(STARTUP) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'((STARTUP > 0) ? STARTUP - 1 : 0);

  state_e          state_q [NCH];
  state_e          state_d [NCH];
  logic [WarmW-1:0] warm_q [NCH];
  logic [WarmW-1:0] warm_d [NCH];
  logic [DIVW-1:0] cnt_q   [NCH];
  logic [DIVW-1:0] cnt_d   [NCH];
  logic [DIVW-1:0] hp_q    [NCH];
  logic [DIVW-1:0] hp_d    [NCH];
  logic [NCH-1:0]  clk_out_q, clk_out_d;
  logic [NCH-1:0]  ready_q, ready_d;
  logic [NCH-1:0]  tick_q, tick_d;

  // A zero divider would never reach hp-1; run it as the fastest setting instead.
  function automatic logic [DIVW-1:0] fix_hp(input logic [DIVW-1:0] d);
    return (d == '0) ? DIVW'(1) : d;
  endfunction

  // Per-channel next-state: warm-up, phase counting, graceful stop.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i]   = state_q[i];
      warm_d[i]    = warm_q[i];
      cnt_d[i]     = cnt_q[i];
      hp_d[i]      = hp_q[i];
      clk_out_d[i] = clk_out_q[i];

      unique case (state_q[i])
        StOff: begin
          if (bus.en[i]) begin
            if (STARTUP == 0) begin
              state_d[i] = StRun;
              cnt_d[i]   = '0;
              hp_d[i]    = fix_hp(bus.div[i*DIVW +: DIVW]);
            end else begin
              state_d[i] = StWarm;
              warm_d[i]  = '0;
            end
          end
        end
        StWarm: begin
          if (!bus.en[i]) begin
            state_d[i] = StOff;
            warm_d[i]  = '0;
          end else if (warm_q[i] == WarmLast) begin
            state_d[i] = StRun;
            warm_d[i]  = '0;
            cnt_d[i]   = '0;
            hp_d[i]    = fix_hp(bus.div[i*DIVW +: DIVW]);
          end else begin
            warm_d[i] = warm_q[i] + WarmW'(1);
          end
        end
        StRun, StStop: begin
          if (!bus.en[i] && !clk_out_q[i]) begin
            // Low phase: stopping here cannot shorten any pulse.
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = bus.en[i] ? StRun : StStop;
            if (cnt_q[i] == hp_q[i] - DIVW'(1)) begin
              clk_out_d[i] = ~clk_out_q[i];
              cnt_d[i]     = '0;
              hp_d[i]      = fix_hp(bus.div[i*DIVW +: DIVW]);
              // High phase completed while disabled: drop straight to OFF.
              if (!bus.en[i]) state_d[i] = StOff;
            end else begin
              cnt_d[i] = cnt_q[i] + DIVW'(1);
            end
          end
        end
      endcase

      ready_d[i] = (state_d[i] == StRun) || (state_d[i] == StStop);
      tick_d[i]  = ~clk_out_q[i] & clk_out_d[i];
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StOff;
        warm_q[i]  <= '0;
        cnt_q[i]   <= '0;
        hp_q[i]    <= '0;
      end
      clk_out_q <= '0;
      ready_q   <= '0;
      tick_q    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        warm_q[i]  <= warm_d[i];
        cnt_q[i]   <= cnt_d[i];
        hp_q[i]    <= hp_d[i];
      end
      clk_out_q <= clk_out_d;
      ready_q   <= ready_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.ready   = ready_q;
  assign bus.tick    = tick_q;

endmodule

// File: doc/rc_clkgen_multi.md
Name: rc_clkgen_multi

Overview:
- Synthesizable, multi-channel successor to the behavioural RC-oscillator clock model.
- Derives NCH independent, enable-gated, programmable-frequency clocks from the single system clock.
- Each channel models oscillator start-up delay, reports a ready status, and starts and stops glitch-free with no runt pulses.
- Feeds peripheral and analog-interface blocks that need slow, switchable clocks, e.g. a 100 kHz class clock.

Parameters:
- NCH, 2, number of independent output channels.
- DIVW, 16, width of each per-channel half-period field.
- STARTUP, 4, warm-up cycles between enable and first clock activity; 0 means no warm-up.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  NCH  per-channel enable; bit i controls channel i.
- div  input  NCH*DIVW  per-channel half-period in clk cycles; channel i uses bits [i*DIVW +: DIVW]; value 0 is treated as 1.
- clk_out  output  NCH  generated clocks, registered.
- ready  output  NCH  channel is in RUN or STOP (clock valid).
- tick  output  NCH  one-cycle pulse, registered together with each 0->1 transition of clk_out.

Behaviour:
- Reset, synchronous and active-high:
  - Next edge: clk_out=0, ready=0, tick=0; every channel goes to OFF; all counters and the latched half-period are 0.
  - Applies mid-operation, including mid-high-phase: the output drops at once.
- Channels are fully independent; the description below is per channel.
- hp = (div==0) ? 1 : div. hp is latched on RUN entry and at every clk_out toggle. A div change therefore takes effect at the next toggle only, never mid-phase.
- OFF:
  - clk_out=0, ready=0.
  - en=1 sampled at an edge: go to WARM with warm counter cleared; if STARTUP==0, go straight to RUN.
- WARM:
  - Counts STARTUP cycles; clk_out stays 0.
  - en=0 goes to OFF on the next edge.
  - When the count completes: go to RUN, set ready=1, phase counter=0, latch hp.
  - Timing: en first sampled high at edge 0 gives ready=1 after edge STARTUP.
- RUN:
  - Phase counter increments every cycle.
  - When counter==hp-1: clk_out toggles, counter clears to 0, hp is re-latched.
  - Period is 2*hp cycles at 50% duty; the first rising edge comes hp cycles after RUN entry.
  - tick=1 in exactly the cycles where clk_out goes 0->1, otherwise 0.
  - en=0 with clk_out=0: go to OFF next edge; ready=0; no further toggles.
  - en=0 with clk_out=1: go to STOP, keep counting.
- STOP:
  - Finishes the current high phase at full length, then clk_out=0, ready=0, state OFF, all in the same edge.
  - en=1 again before the phase completes: return to RUN with no interruption or phase reset.
- Glitch-freedom: a high phase is never shorter than its latched hp, and a low phase is never shorter than hp while in RUN.
- Width rule: the phase counter is DIVW bits, and hp-1 always fits. div at its maximum (2^DIVW-1) must work without wrap.
- en toggled 0->1 during WARM has no effect beyond continuing WARM; warm-up does not restart.

Test Plan:
- Basic timing (STARTUP=4, div0=3, en0 rises and is sampled at edge 0):
  - ready0=1 after edge 4.
  - clk_out0=1 after edges 7–9, 0 after edges 10–12, rises again at edge 13.
  - tick0 high only after edges 7 and 13.
- Graceful stop: deassert en0 two cycles into a high phase (hp=3) -> high phase still lasts 3 cycles, then clk_out0=0 and ready0=0 on the same edge, with no further ticks.
- Stop and re-enable:
  - en0 deasserted during a low phase -> OFF on the next edge.
  - Re-enable -> full STARTUP warm-up before ready0 rises again.
  - en0 pulsed low for 1 cycle during a high phase -> clk_out0 continues with an unbroken period.
- Divider change and edge values:
  - div0 changed 3->5 mid-phase -> current phase completes at 3, the next phase is 5 cycles.
  - div0=0 -> clk_out toggles every cycle (clk/2), tick every 2 cycles.
  - div0=16'hFFFF -> half-period 65535 cycles, no wrap.
- Channel independence and reset:
  - ch0 div=2, ch1 div=7, both enabled -> periods 4 and 14 with no interaction.
  - reset asserted mid-high-phase -> all clk_out, ready and tick are 0 after the next edge.
  - Channels return to OFF and need en plus warm-up to restart.
- STARTUP=0 build: en sampled high at edge 0 -> ready=1 after edge 0, first clk_out rise hp cycles later.
